// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver: synchronise, filter, deframe, fold E0/F0 prefixes into key events.
// Define PS2_KBD_RX_FIFO_EN to buffer events in a 2**FIFO_AW show-ahead FIFO instead of one holding register.
module ps2_kbd_rx #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 2047,
   parameter int FIFO_AW    = 2
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_valid,
   input  logic       key_ready,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       frame_err,
   output logic       overflow,
   output logic       busy
);

   localparam int FCW = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

   function automatic logic odd_parity(input logic [8:0] v);
      return ^v;
   endfunction

   logic           clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
   logic           clk_filt_q;
   logic [FCW-1:0] filt_cnt_q;
   logic           filt_flip_s, fall_s;
   state_t         state_q;
   logic [10:0]    frame_q;
   logic [3:0]     bit_cnt_q;
   logic [11:0]    timer_q;
   logic           ext_pend_q, rel_pend_q, err_q, busy_q;
   logic           frame_ok_s, push_s;
   logic [7:0]     byte_s;
   logic [9:0]     ev_s;

   // Two-flop synchronisers; the line idles high, so reset to 1 avoids a false edge.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         data_s1_q <= 1'b1;
         data_s2_q <= 1'b1;
      end else begin
         clk_s1_q  <= ps2_clk;
         clk_s2_q  <= clk_s1_q;
         data_s1_q <= ps2_data;
         data_s2_q <= data_s1_q;
      end
   end

   always_comb begin
      filt_flip_s = (clk_s2_q != clk_filt_q) && (filt_cnt_q == FCW'(FILTER_LEN - 1));
      fall_s      = filt_flip_s && clk_filt_q;
   end

   // Glitch filter: the accepted clock level moves only after FILTER_LEN agreeing samples.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         clk_filt_q <= 1'b1;
         filt_cnt_q <= '0;
      end else if (clk_s2_q == clk_filt_q) begin
         filt_cnt_q <= '0;
      end else if (filt_flip_s) begin
         clk_filt_q <= clk_s2_q;
         filt_cnt_q <= '0;
      end else begin
         filt_cnt_q <= filt_cnt_q + FCW'(1);
      end
   end

   always_comb begin
      byte_s     = frame_q[8:1];
      frame_ok_s = ~frame_q[0] & frame_q[10] & odd_parity(frame_q[9:1]);
      push_s     = (state_q == S_CHECK) && frame_ok_s && (byte_s != 8'hE0) && (byte_s != 8'hF0);
      ev_s       = {byte_s, ext_pend_q, rel_pend_q};
   end

   // Frame FSM: bit index 0 is start, 1-8 data, 9 parity, 10 stop.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         frame_q    <= '0;
         bit_cnt_q  <= '0;
         timer_q    <= '0;
         ext_pend_q <= 1'b0;
         rel_pend_q <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (fall_s) begin
                  frame_q   <= {10'b0, data_s2_q};
                  bit_cnt_q <= 4'd1;
                  timer_q   <= 12'd0;
                  busy_q    <= 1'b1;
                  state_q   <= S_RECV;
               end
            end
            S_RECV: begin
               if (fall_s) begin
                  frame_q[bit_cnt_q] <= data_s2_q;
                  bit_cnt_q          <= bit_cnt_q + 4'd1;
                  timer_q            <= 12'd0;
                  if (bit_cnt_q == 4'd10) state_q <= S_CHECK;
               end else if (timer_q == 12'(TIMEOUT)) begin
                  err_q      <= 1'b1;
                  ext_pend_q <= 1'b0;
                  rel_pend_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end else begin
                  timer_q <= timer_q + 12'd1;
               end
            end
            S_CHECK: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
               if (!frame_ok_s) begin
                  err_q      <= 1'b1;
                  ext_pend_q <= 1'b0;
                  rel_pend_q <= 1'b0;
               end else if (byte_s == 8'hE0) begin
                  ext_pend_q <= 1'b1;
               end else if (byte_s == 8'hF0) begin
                  rel_pend_q <= 1'b1;
               end else begin
                  ext_pend_q <= 1'b0;
                  rel_pend_q <= 1'b0;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign frame_err = err_q;
   assign busy      = busy_q;

`ifdef PS2_KBD_RX_FIFO_EN
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;

   logic [9:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] rd_q, wr_q;
   logic [CW-1:0]      cnt_q;
   logic               ov_q, pop_s, full_s, write_s;

   always_comb begin
      pop_s   = (cnt_q != '0) && key_ready;
      full_s  = (cnt_q == CW'(DEPTH));
      write_s = push_s && (!full_s || pop_s);
   end

   // Show-ahead FIFO; a full FIFO still accepts a push when the head is popped that cycle.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         ov_q  <= 1'b0;
      end else begin
         ov_q <= push_s && full_s && !pop_s;
         if (write_s) begin
            mem_q[wr_q] <= ev_s;
            wr_q        <= wr_q + FIFO_AW'(1);
         end
         if (pop_s) rd_q <= rd_q + FIFO_AW'(1);
         cnt_q <= cnt_q + CW'(write_s) - CW'(pop_s);
      end
   end

   assign key_valid                          = (cnt_q != '0);
   assign {key_code, key_ext, key_release}   = mem_q[rd_q];
   assign overflow                           = ov_q;
`else
   logic [9:0] hold_q;
   logic       valid_q, ov_q;

   // Single holding register; reloads in the same cycle its current event is accepted.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         hold_q  <= '0;
         valid_q <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         ov_q <= 1'b0;
         if (push_s) begin
            if (!valid_q || key_ready) begin
               hold_q  <= ev_s;
               valid_q <= 1'b1;
            end else begin
               ov_q <= 1'b1;
            end
         end else if (valid_q && key_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign key_valid                        = valid_q;
   assign {key_code, key_ext, key_release} = hold_q;
   assign overflow                         = ov_q;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: hand-built PS/2 frames, events collected on the handshake.
module tb_ps2_kbd_rx;
   localparam int TIMEOUT = 2047;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_ready = 1'b0;
   logic       key_valid, key_ext, key_release, frame_err, overflow, busy;
   logic [7:0] key_code;

   int         checks = 0;
   int         errors = 0;
   int         err_cnt = 0;
   int         ov_cnt = 0;
   int         err_snap, ov_snap;
   logic [9:0] ev_q [$];

   always #5 clk_sys = ~clk_sys;

   ps2_kbd_rx #(.FILTER_LEN(4), .TIMEOUT(TIMEOUT), .FIFO_AW(2)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code), .key_ext(key_ext),
      .key_release(key_release), .frame_err(frame_err), .overflow(overflow), .busy(busy)
   );

   // Record accepted events and pulse counts away from the active edge.
   always @(negedge clk_sys) begin
      if (key_valid && key_ready) ev_q.push_back({key_code, key_ext, key_release});
      if (frame_err) err_cnt++;
      if (overflow) ov_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      tick(15);
      ps2_clk = 1'b0;
      tick(20);
      ps2_clk = 1'b1;
   endtask

   task automatic send(input logic [7:0] d, input logic bad_par);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(~^d ^ bad_par);
      ps2_bit(1'b1);
      tick(40);
   endtask

   task automatic expect_ev(input string tag, input logic [7:0] code, input logic ext, input logic rel);
      logic [9:0] got;
      got = 10'h3FF;
      if (ev_q.size() != 0) got = ev_q.pop_front();
      check_eq(tag, 32'(got), 32'({code, ext, rel}));
   endtask

   initial begin
      tick(5);
      reset_n = 1'b1;
      tick(2);
      check_eq("rst_valid", 32'(key_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_err", 32'(frame_err), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      check_eq("rst_code", 32'({key_code, key_ext, key_release}), 32'd0);

      // 1: plain make code
      key_ready = 1'b1;
      send(8'h1C, 1'b0);
      check_eq("t1_count", 32'(ev_q.size()), 32'd1);
      expect_ev("t1_ev", 8'h1C, 1'b0, 1'b0);
      check_eq("t1_err", 32'(err_cnt), 32'd0);

      // 2: E0 F0 prefixes fold into one event
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      check_eq("t2_noev", 32'(ev_q.size()), 32'd0);
      send(8'h75, 1'b0);
      check_eq("t2_count", 32'(ev_q.size()), 32'd1);
      expect_ev("t2_ev", 8'h75, 1'b1, 1'b1);
      send(8'h1C, 1'b0);
      expect_ev("t2_clr", 8'h1C, 1'b0, 1'b0);

      // 3: parity error clears a pending E0
      err_snap = err_cnt;
      send(8'hE0, 1'b0);
      send(8'h1C, 1'b1);
      check_eq("t3_err", 32'(err_cnt - err_snap), 32'd1);
      check_eq("t3_noev", 32'(ev_q.size()), 32'd0);
      send(8'hF0, 1'b0);
      send(8'h1C, 1'b0);
      expect_ev("t3_ev", 8'h1C, 1'b0, 1'b1);

      // 4: truncated frame times out
      err_snap = err_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      tick(100);
      check_eq("t4_busy_mid", 32'(busy), 32'd1);
      check_eq("t4_err_early", 32'(err_cnt - err_snap), 32'd0);
      tick(TIMEOUT + 10 - 100);
      check_eq("t4_err", 32'(err_cnt - err_snap), 32'd1);
      check_eq("t4_busy", 32'(busy), 32'd0);
      send(8'h75, 1'b0);
      expect_ev("t4_ev", 8'h75, 1'b0, 1'b0);

      // 5: back-pressure
      key_ready = 1'b0;
      ov_snap = ov_cnt;
      send(8'h16, 1'b0);
      send(8'h1E, 1'b0);
      send(8'h26, 1'b0);
      send(8'h25, 1'b0);
      send(8'h2E, 1'b0);
      check_eq("t5_valid", 32'(key_valid), 32'd1);
      check_eq("t5_head", 32'(key_code), 32'h16);
`ifdef PS2_KBD_RX_FIFO_EN
      check_eq("t5_ovf", 32'(ov_cnt - ov_snap), 32'd1);
      key_ready = 1'b1;
      tick(8);
      check_eq("t5_count", 32'(ev_q.size()), 32'd4);
      expect_ev("t5_ev0", 8'h16, 1'b0, 1'b0);
      expect_ev("t5_ev1", 8'h1E, 1'b0, 1'b0);
      expect_ev("t5_ev2", 8'h26, 1'b0, 1'b0);
      expect_ev("t5_ev3", 8'h25, 1'b0, 1'b0);
`else
      check_eq("t5_ovf", 32'(ov_cnt - ov_snap), 32'd4);
      key_ready = 1'b1;
      tick(8);
      check_eq("t5_count", 32'(ev_q.size()), 32'd1);
      expect_ev("t5_ev0", 8'h16, 1'b0, 1'b0);
`endif
      check_eq("t5_empty", 32'(key_valid), 32'd0);

      // 6: reset in the middle of a frame
      err_snap = err_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(i[0]);
      tick(2);
      reset_n = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(10);
      check_eq("t6_busy", 32'(busy), 32'd0);
      check_eq("t6_valid", 32'(key_valid), 32'd0);
      send(8'h1C, 1'b0);
      check_eq("t6_count", 32'(ev_q.size()), 32'd1);
      expect_ev("t6_ev", 8'h1C, 1'b0, 1'b0);
      check_eq("t6_err", 32'(err_cnt - err_snap), 32'd0);

      // 7: stream of events, order preserved across pointer wrap
      for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), 1'b0);
      check_eq("t7_count", 32'(ev_q.size()), 32'd10);
      for (int i = 0; i < 10; i++) expect_ev("t7_ev", 8'h10 + 8'(i), 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
